// File: rtl/branch_resolve.sv
// Resolves an RV32I conditional branch from precomputed compare flags, registers the
// outcome in a one-deep valid/ready stage, pulses a fetch redirect on mispredict, counts events.
module branch_resolve #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 flush,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      pc,
   input  logic [XLEN-1:0]      imm,
   input  logic                 predTaken,
   input  logic                 equal,
   input  logic                 greaterThan,
   input  logic                 lessThan,
   input  logic                 ltUnsigned,
   output logic                 outValid,
   input  logic                 outReady,
   output logic                 taken,
   output logic [XLEN-1:0]      target,
   output logic                 mispredict,
   output logic                 misaligned,
   output logic                 illegal,
   output logic                 redirectValid,
   output logic [XLEN-1:0]      redirectPc,
   output logic [CNT_WIDTH-1:0] branchCount,
   output logic [CNT_WIDTH-1:0] mispredictCount
);

   logic                 r_out_valid;
   logic                 r_taken;
   logic [XLEN-1:0]      r_target;
   logic                 r_mispredict;
   logic                 r_misaligned;
   logic                 r_illegal;
   logic                 r_redirect_valid;
   logic [XLEN-1:0]      r_redirect_pc;
   logic [CNT_WIDTH-1:0] r_branch_count;
   logic [CNT_WIDTH-1:0] r_mispredict_count;

   logic                 w_accept;
   logic                 w_cond;
   logic                 w_legal;
   logic                 w_taken;
   logic                 w_misaligned;
   logic                 w_mispredict;
   logic                 w_redirect;
   logic [XLEN-1:0]      w_sum;
   logic [XLEN-1:0]      w_target;

   assign inReady  = !flush && (!r_out_valid || outReady);
   assign w_accept = inValid && inReady;

   always_comb begin
      w_cond  = 1'b0;
      w_legal = 1'b1;
      case (funct3)
         3'b000:  w_cond = equal;
         3'b001:  w_cond = !equal;
         3'b100:  w_cond = lessThan;
         3'b101:  w_cond = greaterThan || equal;
         3'b110:  w_cond = ltUnsigned;
         3'b111:  w_cond = !ltUnsigned;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_sum        = pc + imm;
   assign w_taken      = w_legal && w_cond;
   assign w_target     = w_taken ? w_sum : pc + XLEN'(4);
   assign w_misaligned = w_taken && (w_sum[1:0] != 2'b00);
   assign w_mispredict = w_legal && (w_taken != predTaken);
   // Only an aligned, legal mispredict may steer fetch.
   assign w_redirect   = w_mispredict && !w_misaligned;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_out_valid  <= 1'b0;
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_mispredict <= 1'b0;
         r_misaligned <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_taken      <= w_taken;
         r_target     <= w_target;
         r_mispredict <= w_mispredict;
         r_misaligned <= w_misaligned;
         r_illegal    <= !w_legal;
      end else if (flush || outReady) begin
         r_out_valid  <= 1'b0;
      end
   end

   // The pulse is tied to the accept edge, so a stalled entry never re-asserts it.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_accept && w_redirect;
         if (w_accept && w_redirect)
            r_redirect_pc <= w_target;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_accept && w_legal && (r_branch_count != '1))
            r_branch_count <= r_branch_count + CNT_WIDTH'(1);
         if (w_accept && w_redirect && (r_mispredict_count != '1))
            r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
      end
   end

   assign outValid        = r_out_valid;
   assign taken           = r_taken;
   assign target          = r_target;
   assign mispredict      = r_mispredict;
   assign misaligned      = r_misaligned;
   assign illegal         = r_illegal;
   assign redirectValid   = r_redirect_valid;
   assign redirectPc      = r_redirect_pc;
   assign branchCount     = r_branch_count;
   assign mispredictCount = r_mispredict_count;

endmodule
